mvm3_stream_driver: RTL

//  Initiator for the 3x3 matrix-vector-multiply (MVM) engine's stream interface. Host loads 12 signed
//  8-bit words (x[0..2], then A row-major) into a local buffer and pulses start. The block streams the

---
 rtl/mvm3_pkg.sv | 27 ++
 rtl/mvm3_stream_driver_if.sv | 36 +++
 rtl/mvm3_stream_driver_buf.sv | 42 ++++
 rtl/mvm3_stream_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mvm3_pkg.sv
`default_nettype none
// ============================================================================
//  Module : mvm3_pkg
//  Brief  : Shared types and constants for the MVM3 stream driver.
//           - state_t : driver FSM states
//           - N_WORDS : operand words streamed per job (3 x + 9 A)
//           - N_RES   : result words collected per job
//           - X_BASE  : buffer index of x[0]
//           - A_BASE  : buffer index of A[0][0]; A[r][c] sits at A_BASE+3r+c
//  Rev    : 1.0  initial release
// ============================================================================
package mvm3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int N_WORDS = 12;
    localparam int N_RES   = 3;
    localparam int X_BASE  = 0;
    localparam int A_BASE  = 3;

endpackage : mvm3_pkg
`default_nettype wire

// File: rtl/mvm3_stream_driver_if.sv
`default_nettype none
// ============================================================================
//  Module : mvm3_stream_driver_if
//  Brief  : Link between the stream driver and the MVM engine.
//           m_valid/m_data/m_ready : operand stream, driver -> MVM
//           r_valid/r_data/r_ready : result stream,  MVM -> driver
//           mvm_ovf                : MVM overflow indication
//           modport master : driver side
//           modport slave  : MVM side
//  Rev    : 1.0  initial release
// ============================================================================
interface mvm3_stream_driver_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) ();

    logic             m_valid;
    logic [IN_W-1:0]  m_data;
    logic             m_ready;
    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic             r_ready;
    logic             mvm_ovf;

    modport master (
        output m_valid, m_data, r_ready,
        input  m_ready, r_valid, r_data, mvm_ovf
    );

    modport slave (
        input  m_valid, m_data, r_ready,
        output m_ready, r_valid, r_data, mvm_ovf
    );

endinterface : mvm3_stream_driver_if
`default_nettype wire

// File: rtl/mvm3_stream_driver_buf.sv
`default_nettype none
// ============================================================================
//  Module : stream_word_buf
//  Brief  : DEPTH x IN_W operand register file, one synchronous write port
//           and one combinational read port. Contents are not reset.
//  Ports  : clk    in   clock, rising edge
//           we     in   write strobe
//           waddr  in   write index (out-of-range writes dropped)
//           wdata  in   write data
//           raddr  in   read index (out-of-range reads return 0)
//           rdata  out  combinational read data
//  Rev    : 1.0  initial release
// ============================================================================
module stream_word_buf
    import mvm3_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int DEPTH = N_WORDS,
    parameter int AW    = 4
) (
    input  wire logic            clk,
    input  wire logic            we,
    input  wire logic [AW-1:0]   waddr,
    input  wire logic [IN_W-1:0] wdata,
    input  wire logic [AW-1:0]   raddr,
    output logic      [IN_W-1:0] rdata
);

    localparam logic [AW-1:0] C_DEPTH = AW'(DEPTH);

    logic [IN_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (waddr < C_DEPTH)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr < C_DEPTH) ? r_mem[raddr] : '0;

endmodule : stream_word_buf
`default_nettype wire

// File: rtl/mvm3_stream_driver.sv
`default_nettype none
// ============================================================================
//  Module : mvm3_stream_driver
//  Brief  : Initiator for the 3x3 MVM engine. The host loads 12 operands
//           (x[0..2], then A row-major), pulses start; the block streams the
//           words to the MVM and collects three results, with sticky
//           overflow and timeout status.
//  Ports  : clk       in   clock, rising edge
//           reset_n   in   asynchronous active-low reset
//           ld_en     in   host buffer write strobe (IDLE only)
//           ld_addr   in   buffer index 0..11
//           ld_data   in   signed operand
//           start     in   single-cycle job launch (IDLE only)
//           busy      out  high from start accept until done
//           done      out  one-cycle pulse at job end
//           mvm       --   master modport: operand/result streams, overflow
//           ovf_flag  out  sticky: mvm_ovf seen during job
//           timeout   out  sticky: job aborted on result timeout
//           rd_addr   in   result index 0..2
//           rd_data   out  combinational read of result[rd_addr]
//  Rev    : 1.0  initial release
// ============================================================================
module mvm3_stream_driver
    import mvm3_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             ld_en,
    input  wire logic [3:0]       ld_addr,
    input  wire logic [IN_W-1:0]  ld_data,
    input  wire logic             start,
    output logic                  busy,
    output logic                  done,
    mvm3_stream_driver_if.master  mvm,
    output logic                  ovf_flag,
    output logic                  timeout,
    input  wire logic [1:0]       rd_addr,
    output logic      [OUT_W-1:0] rd_data
);

    localparam int              IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] C_IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic [3:0]      C_LAST_WORD = 4'(N_WORDS - 1);
    localparam logic [1:0]      C_LAST_RES  = 2'(N_RES - 1);

    state_t             r_state;
    logic [3:0]         r_wcnt;
    logic [1:0]         r_rcnt;
    logic [IDLE_W-1:0]  r_idle;
    logic               r_m_valid;
    logic [IN_W-1:0]    r_m_data;
    logic               r_r_ready;
    logic               r_done;
    logic               r_ovf;
    logic               r_timeout;
    logic [OUT_W-1:0]   r_results [N_RES];

    logic [3:0]         w_rd_idx;
    logic [IN_W-1:0]    w_rd_word;
    logic               w_buf_we;

    // The buffer is read one word ahead so m_data can be loaded into a
    // register on the same edge that accepts the current word.
    assign w_rd_idx = (r_state == IDLE) ? 4'd0 : 4'(r_wcnt + 4'd1);
    assign w_buf_we = ld_en && (r_state == IDLE);

    stream_word_buf #(
        .IN_W  (IN_W),
        .DEPTH (N_WORDS),
        .AW    (4)
    ) u_buf (
        .clk   (clk),
        .we    (w_buf_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (w_rd_idx),
        .rdata (w_rd_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_wcnt    <= 4'd0;
            r_rcnt    <= 2'd0;
            r_idle    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_r_ready <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_timeout <= 1'b0;
            for (int i = 0; i < N_RES; i++) begin
                r_results[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if ((r_state != IDLE) && mvm.mvm_ovf) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= SEND;
                        r_m_valid <= 1'b1;
                        r_m_data  <= w_rd_word;
                        r_wcnt    <= 4'd0;
                        r_rcnt    <= 2'd0;
                        r_idle    <= '0;
                        r_ovf     <= 1'b0;
                        r_timeout <= 1'b0;
                        for (int i = 0; i < N_RES; i++) begin
                            r_results[i] <= '0;
                        end
                    end
                end

                SEND: begin
                    if (mvm.m_ready) begin
                        if (r_wcnt == C_LAST_WORD) begin
                            r_state   <= RECV;
                            r_m_valid <= 1'b0;
                            r_r_ready <= 1'b1;
                            r_idle    <= '0;
                        end else begin
                            r_wcnt   <= r_wcnt + 4'd1;
                            r_m_data <= w_rd_word;
                        end
                    end
                end

                RECV: begin
                    if (mvm.r_valid) begin
                        r_results[r_rcnt] <= mvm.r_data;
                        r_idle            <= '0;
                        if (r_rcnt == C_LAST_RES) begin
                            r_state   <= FIN;
                            r_r_ready <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_rcnt <= r_rcnt + 2'd1;
                        end
                    end else if (r_idle == C_IDLE_MAX) begin
                        r_timeout <= 1'b1;
                        r_state   <= FIN;
                        r_r_ready <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end

                FIN: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign ovf_flag    = r_ovf;
    assign timeout     = r_timeout;
    assign mvm.m_valid = r_m_valid;
    assign mvm.m_data  = r_m_data;
    assign mvm.r_ready = r_r_ready;
    assign rd_data     = (rd_addr <= C_LAST_RES) ? r_results[rd_addr] : '0;

endmodule : mvm3_stream_driver
`default_nettype wire
